// File: rtl/uart_pkg.sv
// uart_pkg: bus addresses, CON bit positions, FSM state codes and baud divisor helper
package uart_pkg;
    localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
    localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
    localparam logic [31:0] ADDR_CON = 32'h4000_0020;
    localparam int CON_TX_IRQ_EN = 0;
    localparam int CON_RX_IRQ_EN = 1;
    localparam int CON_TX_DONE   = 2;
    localparam int CON_RX_READY  = 3;
    localparam int CON_TX_BUSY   = 4;
    localparam int CON_FERR      = 5;
    localparam int CON_OVERRUN   = 6;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;
    localparam int OVERSAMPLE = 16;
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud * OVERSAMPLE / 2) / (baud * OVERSAMPLE);
    endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: divides the system clock into a one-cycle oversample tick; clr restarts the period
module uart_baud_gen #(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: memory-mapped 8N1 UART with 16x oversampled RX/TX, CON status register and level irq
module uart_mmio_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_write,
    input  logic        mem_read,
    output logic [31:0] rdata,
    input  logic        UART_RX,
    output logic        UART_TX,
    output logic        irq
);
    localparam int DIV = calc_div(CLK_HZ, BAUD);
    logic       wr_txd, wr_con, rd_con, unused_wdata;
    logic       rx_s1_q, rx_s2_q, rx_clr, rx_tick, rx_ok, rx_bad;
    logic [1:0] rx_st_q, rx_st_d;
    logic [3:0] rx_tk_q, rx_tk_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_sh_q, rx_sh_d;
    logic       tx_clr, tx_tick, tx_fin, tx_busy, tx_line_q, tx_line_d;
    logic [1:0] tx_st_q, tx_st_d;
    logic [3:0] tx_tk_q, tx_tk_d;
    logic [2:0] tx_bit_q, tx_bit_d;
    logic [7:0] tx_sh_q, tx_sh_d;
    logic [1:0] en_q, en_d;
    logic       tx_done_q, tx_done_d, rx_ready_q, rx_ready_d;
    logic       ferr_q, ferr_d, ovr_q, ovr_d, irq_q, irq_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic [6:0] con;

    uart_baud_gen #(.DIV(DIV)) u_rx_baud (.clk(sysclk), .rst_n(reset), .clr(rx_clr), .tick(rx_tick));
    uart_baud_gen #(.DIV(DIV)) u_tx_baud (.clk(sysclk), .rst_n(reset), .clr(tx_clr), .tick(tx_tick));

    assign wr_txd       = mem_write && (addr == ADDR_TXD);
    assign wr_con       = mem_write && (addr == ADDR_CON);
    assign rd_con       = mem_read && (addr == ADDR_CON);
    assign unused_wdata = ^wdata[31:8];
    assign tx_busy      = (tx_st_q != ST_IDLE);
    assign UART_TX      = tx_line_q;
    assign irq          = irq_q;

    always_comb begin
        rx_st_d  = rx_st_q;
        rx_tk_d  = rx_tk_q;
        rx_bit_d = rx_bit_q;
        rx_sh_d  = rx_sh_q;
        rx_clr   = 1'b0;
        rx_ok    = 1'b0;
        rx_bad   = 1'b0;
        if (rx_st_q == ST_IDLE) begin
            if (!rx_s2_q) begin
                rx_st_d = ST_START;
                rx_tk_d = '0;
                rx_clr  = 1'b1;
            end
        end else if (rx_tick) begin
            rx_tk_d = rx_tk_q + 4'd1;
            // start bit is re-checked at mid-bit so short glitches fall back to idle
            if (rx_st_q == ST_START && rx_tk_q == 4'd7) begin
                rx_st_d  = rx_s2_q ? ST_IDLE : ST_DATA;
                rx_tk_d  = '0;
                rx_bit_d = '0;
            end else if (rx_st_q == ST_DATA && rx_tk_q == 4'd15) begin
                rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                rx_st_d  = (rx_bit_q == 3'd7) ? ST_STOP : ST_DATA;
            end else if (rx_st_q == ST_STOP && rx_tk_q == 4'd15) begin
                rx_st_d = ST_IDLE;
                rx_ok   = rx_s2_q;
                rx_bad  = !rx_s2_q;
            end
        end
    end

    always_comb begin
        tx_st_d   = tx_st_q;
        tx_tk_d   = tx_tk_q;
        tx_bit_d  = tx_bit_q;
        tx_sh_d   = tx_sh_q;
        tx_line_d = tx_line_q;
        tx_clr    = 1'b0;
        tx_fin    = 1'b0;
        if (tx_st_q == ST_IDLE) begin
            if (wr_txd) begin
                tx_st_d   = ST_START;
                tx_sh_d   = wdata[7:0];
                tx_tk_d   = '0;
                tx_clr    = 1'b1;
                tx_line_d = 1'b0;
            end
        end else if (tx_tick) begin
            tx_tk_d = tx_tk_q + 4'd1;
            if (tx_tk_q == 4'd15) begin
                if (tx_st_q == ST_START) begin
                    tx_st_d   = ST_DATA;
                    tx_bit_d  = '0;
                    tx_line_d = tx_sh_q[0];
                end else if (tx_st_q == ST_DATA) begin
                    tx_sh_d   = {1'b0, tx_sh_q[7:1]};
                    tx_bit_d  = tx_bit_q + 3'd1;
                    tx_line_d = (tx_bit_q == 3'd7) ? 1'b1 : tx_sh_q[1];
                    tx_st_d   = (tx_bit_q == 3'd7) ? ST_STOP : ST_DATA;
                end else begin
                    tx_st_d = ST_IDLE;
                    tx_fin  = 1'b1;
                end
            end
        end
    end

    // a flag being set in the same cycle as a CON read survives the read-clear
    always_comb begin
        en_d       = wr_con ? wdata[1:0] : en_q;
        tx_done_d  = tx_fin | (tx_done_q & ~rd_con);
        rx_ready_d = rx_ok | (rx_ready_q & ~rd_con);
        ferr_d     = rx_bad | (ferr_q & ~rd_con);
        ovr_d      = (rx_ok & rx_ready_q) | (ovr_q & ~rd_con);
        rx_data_d  = rx_ok ? rx_sh_q : rx_data_q;
        irq_d      = (en_q[0] & tx_done_q) | (en_q[1] & rx_ready_q);
    end

    always_comb begin
        con                = '0;
        con[CON_TX_IRQ_EN] = en_q[0];
        con[CON_RX_IRQ_EN] = en_q[1];
        con[CON_TX_DONE]   = tx_done_q;
        con[CON_RX_READY]  = rx_ready_q;
        con[CON_TX_BUSY]   = tx_busy;
        con[CON_FERR]      = ferr_q;
        con[CON_OVERRUN]   = ovr_q;
        rdata = !mem_read           ? 32'd0 :
                (addr == ADDR_RXD)  ? {24'd0, rx_data_q} :
                (addr == ADDR_CON)  ? {25'd0, con} : 32'd0;
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_st_q    <= ST_IDLE;
            rx_tk_q    <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            tx_st_q    <= ST_IDLE;
            tx_tk_q    <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_line_q  <= 1'b1;
            en_q       <= '0;
            tx_done_q  <= 1'b0;
            rx_ready_q <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
            rx_data_q  <= '0;
            irq_q      <= 1'b0;
        end else begin
            rx_s1_q    <= UART_RX;
            rx_s2_q    <= rx_s1_q;
            rx_st_q    <= rx_st_d;
            rx_tk_q    <= rx_tk_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            tx_st_q    <= tx_st_d;
            tx_tk_q    <= tx_tk_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_line_q  <= tx_line_d;
            en_q       <= en_d;
            tx_done_q  <= tx_done_d;
            rx_ready_q <= rx_ready_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
            rx_data_q  <= rx_data_d;
            irq_q      <= irq_d;
        end
    end
endmodule
